// File: rtl/game_pkg.sv
// Shared types and constants for the match-clock sequencer.
//   clk_state_e   : sequencer states
//   BCD_W         : width of one BCD digit / load-data bus
//   SEC_TENS_WRAP : value reloaded into the sec-tens digit when it borrows
//   FREEZE_W      : width of the post-goal freeze counter
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_FREEZE  = 3'd4,
    ST_EXPIRED = 3'd5
  } clk_state_e;

  localparam int              BCD_W         = 4;
  localparam logic [BCD_W-1:0] SEC_TENS_WRAP = 4'd5;
  localparam int              FREEZE_W      = 4;

endpackage

// File: rtl/freeze_timer.sv
// Post-goal freeze timer: loadable down counter stepped by one_sec ticks.
// Ports:
//   clk        in  system clock
//   resetN     in  asynchronous active-low reset (count clears to 0)
//   load_i     in  load load_val_i (has priority over a tick)
//   load_val_i in  FREEZE_W-bit reload value
//   tick_i     in  one-second tick, counts down while non-zero
//   done_o     out tick that takes the count from 1 to 0
module freeze_timer
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                resetN,
  input  logic                load_i,
  input  logic [FREEZE_W-1:0] load_val_i,
  input  logic                tick_i,
  output logic                done_o
);

  logic [FREEZE_W-1:0] cnt_q;
  logic [FREEZE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Deliberately independent of load_i so the parent's next-state logic has
  // no combinational loop; the parent only looks at done_o when no goal is
  // pending.
  assign done_o = tick_i && (cnt_q == FREEZE_W'(1));

endmodule

// File: rtl/game_clock_ctrl.sv
// Match-clock sequencer. Drives three cascaded BCD down-counter digits
// (minutes, sec-tens, sec-units) with per-digit enables and loads, wraps the
// sec-tens digit 0->5, stops at 0:00 and reports time-up.
// Ports:
//   clk, resetN                        clock, asynchronous active-low reset
//   start_game, pause_toggle, goal     1-cycle control pulses
//   one_sec                            1-cycle tick once per second
//   tc_units, tc_tens, tc_mins         digit-is-zero flags from the counters
//   ena_units/tens/mins                decrement enables to the digits
//   loadN_units/tens/mins              active-low loads to the digits
//   din_units/tens/mins                load data to the digits
//   running                            clock is counting (RUN)
//   time_up                            match time expired (EXPIRED)
module game_clock_ctrl
  import game_pkg::*;
#(
  parameter int INIT_MIN    = 3,
  parameter int INIT_TENS   = 0,
  parameter int INIT_UNITS  = 0,
  parameter int FREEZE_SECS = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start_game,
  input  logic             pause_toggle,
  input  logic             goal,
  input  logic             one_sec,
  input  logic             tc_units,
  input  logic             tc_tens,
  input  logic             tc_mins,
  output logic             ena_units,
  output logic             ena_tens,
  output logic             ena_mins,
  output logic             loadN_units,
  output logic             loadN_tens,
  output logic             loadN_mins,
  output logic [BCD_W-1:0] din_units,
  output logic [BCD_W-1:0] din_tens,
  output logic [BCD_W-1:0] din_mins,
  output logic             running,
  output logic             time_up
);

  clk_state_e state_q;
  clk_state_e state_d;

  logic expire_cond;
  logic freeze_load;
  logic freeze_tick;
  logic freeze_done;

  // All three digits at zero: the clock reads 0:00.
  assign expire_cond = tc_units && tc_tens && tc_mins;
  assign freeze_tick = one_sec && (state_q == ST_FREEZE);

  freeze_timer u_freeze_timer (
    .clk        (clk),
    .resetN     (resetN),
    .load_i     (freeze_load),
    .load_val_i (FREEZE_W'(FREEZE_SECS)),
    .tick_i     (freeze_tick),
    .done_o     (freeze_done)
  );

  // Next-state logic; start_game overrides everything.
  always_comb begin
    state_d     = state_q;
    freeze_load = 1'b0;
    if (start_game) begin
      state_d = ST_LOAD;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (expire_cond) begin
            state_d = ST_EXPIRED;
          end else if (goal) begin
            state_d     = ST_FREEZE;
            freeze_load = 1'b1;
          end else if (pause_toggle) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (goal) begin
            state_d     = ST_FREEZE;
            freeze_load = 1'b1;
          end else if (pause_toggle) begin
            state_d = ST_RUN;
          end
        end
        ST_FREEZE: begin
          // A further goal restarts the freeze; pause_toggle is ignored.
          if (goal) begin
            freeze_load = 1'b1;
          end else if (freeze_done) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Digit controls. Any concurrent control pulse suppresses the decrement so
  // that the second in which it arrives is not consumed.
  always_comb begin
    ena_units   = (state_q == ST_RUN) && one_sec && !expire_cond
                  && !goal && !start_game && !pause_toggle;
    ena_tens    = ena_units && tc_units;
    ena_mins    = ena_tens && tc_tens;
    loadN_units = 1'b1;
    loadN_tens  = 1'b1;
    loadN_mins  = 1'b1;
    din_units   = '0;
    din_tens    = '0;
    din_mins    = '0;
    if (state_q == ST_LOAD) begin
      loadN_units = 1'b0;
      loadN_tens  = 1'b0;
      loadN_mins  = 1'b0;
      din_units   = BCD_W'(INIT_UNITS);
      din_tens    = BCD_W'(INIT_TENS);
      din_mins    = BCD_W'(INIT_MIN);
    end else if (ena_tens && tc_tens) begin
      // Tens digit borrows from minutes: reload 5 instead of counting to 9.
      loadN_tens = 1'b0;
      din_tens   = SEC_TENS_WRAP;
    end
    running = (state_q == ST_RUN);
    time_up = (state_q == ST_EXPIRED);
  end

endmodule

// File: tb/tb_game_clock_ctrl.sv
module tb_game_clock_ctrl;

  localparam int P_MIN   = 3;
  localparam int P_TENS  = 0;
  localparam int P_UNITS = 0;
  localparam int P_FRZ   = 3;

  // Behavioural model modes (the model's own labels)
  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_RUN    = 2;
  localparam int M_PAUSE  = 3;
  localparam int M_FREEZE = 4;
  localparam int M_OVER   = 5;

  logic clk = 1'b0;
  logic resetN;
  logic start_game, pause_toggle, goal, one_sec;
  logic tc_units, tc_tens, tc_mins;
  logic ena_units, ena_tens, ena_mins;
  logic loadN_units, loadN_tens, loadN_mins;
  logic [3:0] din_units, din_tens, din_mins;
  logic running, time_up;

  always #5 clk = ~clk;

  game_clock_ctrl #(
    .INIT_MIN   (P_MIN),
    .INIT_TENS  (P_TENS),
    .INIT_UNITS (P_UNITS),
    .FREEZE_SECS(P_FRZ)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .start_game  (start_game),
    .pause_toggle(pause_toggle),
    .goal        (goal),
    .one_sec     (one_sec),
    .tc_units    (tc_units),
    .tc_tens     (tc_tens),
    .tc_mins     (tc_mins),
    .ena_units   (ena_units),
    .ena_tens    (ena_tens),
    .ena_mins    (ena_mins),
    .loadN_units (loadN_units),
    .loadN_tens  (loadN_tens),
    .loadN_mins  (loadN_mins),
    .din_units   (din_units),
    .din_tens    (din_tens),
    .din_mins    (din_mins),
    .running     (running),
    .time_up     (time_up)
  );

  // Environment: three BCD 9..0 down-counter digits driven by the DUT
  logic [3:0] d_units, d_tens, d_mins;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      d_units <= 4'd0;
      d_tens  <= 4'd0;
      d_mins  <= 4'd0;
    end else begin
      if (!loadN_units) d_units <= din_units;
      else if (ena_units) d_units <= (d_units == 4'd0) ? 4'd9 : d_units - 4'd1;
      if (!loadN_tens) d_tens <= din_tens;
      else if (ena_tens) d_tens <= (d_tens == 4'd0) ? 4'd9 : d_tens - 4'd1;
      if (!loadN_mins) d_mins <= din_mins;
      else if (ena_mins) d_mins <= (d_mins == 4'd0) ? 4'd9 : d_mins - 4'd1;
    end
  end

  assign tc_units = (d_units == 4'd0);
  assign tc_tens  = (d_tens == 4'd0);
  assign tc_mins  = (d_mins == 4'd0);

  logic [19:0] got_vec;
  assign got_vec = {running, time_up, ena_units, ena_tens, ena_mins,
                    loadN_units, loadN_tens, loadN_mins,
                    din_units, din_tens, din_mins};

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: match time as seconds remaining
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_frz  = 0;

  function automatic int digit_secs();
    return int'(d_mins) * 60 + int'(d_tens) * 10 + int'(d_units);
  endfunction

  function automatic logic [19:0] mk(input logic run, input logic tu,
                                     input logic [2:0] ena, input logic [2:0] ldn,
                                     input int du, input int dt, input int dm);
    return {run, tu, ena, ldn, 4'(du), 4'(dt), 4'(dm)};
  endfunction

  // Expected outputs: a second is consumed only in RUN with time left and no
  // other control pulse; borrows follow from the remaining-time arithmetic.
  function automatic logic [19:0] model_out(input logic sg, input logic pt,
                                            input logic gl, input logic os);
    logic dec, borrow_u, borrow_t, loading;
    int   u, t;
    u        = m_secs % 10;
    t        = (m_secs / 10) % 6;
    loading  = (m_mode == M_LOAD);
    dec      = (m_mode == M_RUN) && os && (m_secs != 0) && !gl && !sg && !pt;
    borrow_u = dec && (u == 0);
    borrow_t = borrow_u && (t == 0);
    return mk(m_mode == M_RUN, m_mode == M_OVER,
              {dec, borrow_u, borrow_t},
              {!loading, !(loading || borrow_t), !loading},
              loading ? P_UNITS : 0,
              loading ? P_TENS : (borrow_t ? 5 : 0),
              loading ? P_MIN : 0);
  endfunction

  task automatic model_adv(input logic sg, input logic pt, input logic gl, input logic os);
    if (m_mode == M_LOAD) m_secs = P_MIN * 60 + P_TENS * 10 + P_UNITS;
    if (sg) begin
      m_mode = M_LOAD;
    end else begin
      case (m_mode)
        M_LOAD: m_mode = M_RUN;
        M_RUN: begin
          if (m_secs == 0) m_mode = M_OVER;
          else if (gl) begin m_mode = M_FREEZE; m_frz = P_FRZ; end
          else if (pt) m_mode = M_PAUSE;
          else if (os) m_secs = m_secs - 1;
        end
        M_PAUSE: begin
          if (gl) begin m_mode = M_FREEZE; m_frz = P_FRZ; end
          else if (pt) m_mode = M_RUN;
        end
        M_FREEZE: begin
          if (gl) m_frz = P_FRZ;
          else if (os) begin
            m_frz = m_frz - 1;
            if (m_frz == 0) m_mode = M_RUN;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_vec(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs {run,tu,ena3,ldN3,du,dt,dm} got %05h required %05h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: clock seconds got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic sg, input logic pt, input logic gl, input logic os,
                      input string name, input logic use_ext,
                      input logic [19:0] ext_vec, input int ext_secs);
    @(negedge clk);
    start_game = sg; pause_toggle = pt; goal = gl; one_sec = os;
    #1;
    check_vec({name, "_model"}, got_vec, model_out(sg, pt, gl, os));
    if (use_ext) check_vec({name, "_fixed"}, got_vec, ext_vec);
    @(posedge clk);
    model_adv(sg, pt, gl, os);
    #1;
    check_int({name, "_time"}, digit_secs(), m_secs);
    if (use_ext) check_int({name, "_time_fixed"}, digit_secs(), ext_secs);
    $display("step %-18s sg=%0b pt=%0b gl=%0b os=%0b out=%05h clock=%0d:%0d%0d",
             name, sg, pt, gl, os, got_vec, d_mins, d_tens, d_units);
  endtask

  task automatic tick(input logic sg, input logic pt, input logic gl, input logic os,
                      input string name);
    step(sg, pt, gl, os, name, 1'b0, 20'h0, 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    resetN = 1'b0;
    start_game = 1'b0; pause_toggle = 1'b0; goal = 1'b0; one_sec = 1'b0;
    #1;
    check_vec({name, "_outputs"}, got_vec, mk(0, 0, 3'b000, 3'b111, 0, 0, 0));
    check_int({name, "_digits"}, digit_secs(), 0);
    m_mode = M_IDLE; m_secs = 0; m_frz = 0;
    @(negedge clk);
    resetN = 1'b1;
    $display("reset %s applied", name);
  endtask

  typedef struct {
    logic sg, pt, gl, os;
    logic run, tu;
    logic [2:0] ena, ldn;
    int du, dt, dm;
    int secs;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    start_game = 1'b0; pause_toggle = 1'b0; goal = 1'b0; one_sec = 1'b0;

    //          sg   pt   gl   os   run  tu   ena     ldn    du dt dm secs
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,3'b111,0,0,0,0};   // idle
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,3'b111,0,0,0,0};   // start
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,0,0,3,180}; // load
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'b000,3'b111,0,0,0,180}; // run
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,3'b111,3'b101,0,5,0,179}; // 3:00->2:59
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,3'b100,3'b111,0,0,0,178};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,3'b000,3'b111,0,0,0,178}; // pause+tick
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'b000,3'b111,0,0,0,178}; // paused
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,3'b111,0,0,0,178}; // resume
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,3'b000,3'b111,0,0,0,178}; // goal+tick
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'b000,3'b111,0,0,0,178};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'b000,3'b111,0,0,0,178};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'b000,3'b111,0,0,0,178}; // 3rd tick
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,3'b100,3'b111,0,0,0,177}; // counts

    do_reset("power_on");

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].sg, tbl[i].pt, tbl[i].gl, tbl[i].os, $sformatf("vec%0d", i), 1'b1,
           mk(tbl[i].run, tbl[i].tu, tbl[i].ena, tbl[i].ldn, tbl[i].du, tbl[i].dt, tbl[i].dm),
           tbl[i].secs);
    end

    // 1:00 -> 0:59 tens wrap
    for (int k = 0; k < 200 && digit_secs() != 60; k++) tick(0, 0, 0, 1, "run_to_1_00");
    check_int("reach_1_00", digit_secs(), 60);
    step(0, 0, 0, 1, "wrap_1_00", 1'b1, mk(1, 0, 3'b111, 3'b101, 0, 5, 0), 59);

    // Run down to 0:00 and expire
    for (int k = 0; k < 100 && digit_secs() != 1; k++) tick(0, 0, 0, 1, "run_to_0_01");
    check_int("reach_0_01", digit_secs(), 1);
    step(0, 0, 0, 1, "last_tick",    1'b1, mk(1, 0, 3'b100, 3'b111, 0, 0, 0), 0);
    step(0, 0, 0, 1, "expire_cycle", 1'b1, mk(1, 0, 3'b000, 3'b111, 0, 0, 0), 0);
    step(0, 0, 0, 1, "expired_tick", 1'b1, mk(0, 1, 3'b000, 3'b111, 0, 0, 0), 0);
    step(0, 1, 1, 1, "expired_hold", 1'b1, mk(0, 1, 3'b000, 3'b111, 0, 0, 0), 0);

    // Restart from EXPIRED
    step(1, 0, 0, 0, "restart_pulse", 1'b1, mk(0, 1, 3'b000, 3'b111, 0, 0, 0), 0);
    step(0, 0, 0, 0, "restart_load",  1'b1, mk(0, 0, 3'b000, 3'b000, 0, 0, 3), 180);
    step(0, 0, 0, 1, "restart_run",   1'b1, mk(1, 0, 3'b111, 3'b101, 0, 5, 0), 179);

    // Freeze: pause ignored, goal reloads the count
    step(0, 0, 1, 0, "goal_run",        1'b1, mk(1, 0, 3'b000, 3'b111, 0, 0, 0), 179);
    step(0, 1, 0, 1, "frz_pause_ign",   1'b1, mk(0, 0, 3'b000, 3'b111, 0, 0, 0), 179);
    step(0, 0, 1, 1, "frz_goal_reload", 1'b1, mk(0, 0, 3'b000, 3'b111, 0, 0, 0), 179);
    tick(0, 0, 0, 1, "frz_tick1");
    tick(0, 0, 0, 1, "frz_tick2");
    step(0, 0, 0, 1, "frz_tick3",  1'b1, mk(0, 0, 3'b000, 3'b111, 0, 0, 0), 179);
    step(0, 0, 0, 1, "after_frz",  1'b1, mk(1, 0, 3'b100, 3'b111, 0, 0, 0), 178);

    // Reset in the middle of a running match
    do_reset("mid_run");

    // Randomised phase against the model
    tick(1, 0, 0, 0, "rand_start");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset("rand_reset");
      end else begin
        tick($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 0, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
